// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns stage with valid/ready on both sides.
// COLS_PER_CYCLE columns are transformed per BUSY cycle; bypass skips the mix entirely.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] mix_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv_en,
  input  logic         bypass_en,
  output logic [127:0] mix_o,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy_o
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // One output byte: p is the byte's own row, q/s/t follow in rotation.
  function automatic logic [7:0] mix_byte(input logic [7:0] p, input logic [7:0] q,
                                          input logic [7:0] s, input logic [7:0] t,
                                          input logic inv);
    logic [7:0] p2, p4, p8, q2, q4, q8, s2, s4, s8, t2, t4, t8;
    p2 = xtime(p);  p4 = xtime(p2); p8 = xtime(p4);
    q2 = xtime(q);  q4 = xtime(q2); q8 = xtime(q4);
    s2 = xtime(s);  s4 = xtime(s2); s8 = xtime(s4);
    t2 = xtime(t);  t4 = xtime(t2); t8 = xtime(t4);
    if (inv)
      return (p8 ^ p4 ^ p2) ^ (q8 ^ q2 ^ q) ^ (s8 ^ s4 ^ s) ^ (t8 ^ t);
    else
      return p2 ^ (q2 ^ q) ^ s ^ t;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {mix_byte(a0, a1, a2, a3, inv), mix_byte(a1, a2, a3, a0, inv),
            mix_byte(a2, a3, a0, a1, inv), mix_byte(a3, a0, a1, a2, inv)};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t       r_state;
  logic [1:0]   r_col;
  logic [127:0] r_data;
  logic [127:0] r_mix_o;
  logic         r_inv;
  logic         r_out_valid;
  logic         r_in_ready;
  logic         r_busy;

  logic [1:0]   w_idx     [COLS_PER_CYCLE];
  logic [31:0]  w_col_in  [COLS_PER_CYCLE];
  logic [31:0]  w_col_out [COLS_PER_CYCLE];
  logic [127:0] w_data_next;
  logic         w_last;

  // Column c lives at bits [(3-c)*32 +: 32]; for a 2-bit c, 3-c is simply ~c.
  generate
    for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
      assign w_idx[gi]     = r_col + 2'(gi);
      assign w_col_in[gi]  = r_data[{~w_idx[gi], 5'd0} +: 32];
      assign w_col_out[gi] = mix_col(w_col_in[gi], r_inv);
    end
  endgenerate

  always_comb begin
    w_data_next = r_data;
    for (int k = 0; k < COLS_PER_CYCLE; k++)
      w_data_next[{~w_idx[k], 5'd0} +: 32] = w_col_out[k];
  end

  assign w_last = (({1'b0, r_col} + 3'(COLS_PER_CYCLE)) == 3'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_col       <= 2'd0;
      r_data      <= '0;
      r_mix_o     <= '0;
      r_inv       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data     <= mix_in;
            r_inv      <= inv_en;
            r_col      <= 2'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (bypass_en) begin
              r_state     <= S_DONE;
              r_mix_o     <= mix_in;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_data <= w_data_next;
          r_col  <= r_col + 2'(COLS_PER_CYCLE);
          if (w_last) begin
            r_state     <= S_DONE;
            r_mix_o     <= w_data_next;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mix_o     = r_mix_o;
  assign out_valid = r_out_valid;
  assign busy_o    = r_busy;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: three instances (1, 2 and 4 columns per cycle) share one stimulus.
// Vectors come from a table; expected results go through a queue and are matched on out_valid.
module tb_mix_columns_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] mix_in;
  logic         in_valid;
  logic         inv_en;
  logic         bypass_en;
  logic         out_ready;

  logic [2:0][127:0] mix_o_w;
  logic [2:0]        in_ready_w;
  logic [2:0]        out_valid_w;
  logic [2:0]        busy_w;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int C = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
      mix_columns_iter #(.COLS_PER_CYCLE(C)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mix_in    (mix_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w[gi]),
        .inv_en    (inv_en),
        .bypass_en (bypass_en),
        .mix_o     (mix_o_w[gi]),
        .out_valid (out_valid_w[gi]),
        .out_ready (out_ready),
        .busy_o    (busy_w[gi])
      );
    end
  endgenerate

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic         byp;
    logic [127:0] dout;
  } vec_t;

  typedef struct {
    int           inst;
    logic [127:0] data;
    int           lat;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   lat_tab[3] = '{5, 3, 2};
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int inst, input logic [127:0] act,
                       input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s inst%0d: got %h expected %h", name, inst, act, exp);
    end
  endtask

  // Drive one block, then match every instance's output against the scoreboard.
  task automatic run_block(input string name, input logic [127:0] din, input logic inv,
                           input logic byp, input logic [127:0] dout);
    logic [2:0] seen;
    int n;
    exp_t e;
    @(negedge clk);
    mix_in = din; inv_en = inv; bypass_en = byp; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) check({name, " in_ready"}, k, 128'(in_ready_w[k]), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) sb.push_back('{k, dout, byp ? 1 : lat_tab[k]});
    seen = 3'b000;
    n = 0;
    while (seen != 3'b111 && n < 20) begin
      for (int k = 0; k < 3; k++) begin
        if (!seen[k] && out_valid_w[k]) begin
          seen[k] = 1'b1;
          for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].inst == k) begin
              e = sb[i];
              sb.delete(i);
              break;
            end
          end
          check({name, " data"}, k, mix_o_w[k], e.data);
          check({name, " latency"}, k, 128'(n + 1), 128'(e.lat));
          $display("[TB] %s inst%0d latency %0d mix_o %h", name, k, n + 1, mix_o_w[k]);
        end
      end
      if (seen != 3'b111) begin
        @(posedge clk); #1;
        n++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (!seen[k]) begin
        n_tests++; n_fail++;
        $display("[TB] FAIL %s inst%0d: out_valid timeout got 0 expected 1", name, k);
      end
    end
    sb.delete();
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) check({name, " back to idle"}, k, 128'(in_ready_w[k]), 128'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] hold_exp;
    logic [2:0]   all_valid;
    int           n;

    vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0,
                128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    vecs[1] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 1'b0,
                128'hdb135345_f20a225c_01010101_c6c6c6c6};
    vecs[2] = '{128'hd4d4d4d5_2d26314c_00112233_44556677, 1'b0, 1'b1,
                128'hd4d4d4d5_2d26314c_00112233_44556677};
    vecs[3] = '{128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5, 1'b0, 1'b0,
                128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6};
    vecs[4] = '{128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6, 1'b1, 1'b0,
                128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5};
    vecs[5] = '{128'hd4d4d4d5_01010101_c6c6c6c6_db135345, 1'b0, 1'b0,
                128'hd5d5d7d6_01010101_c6c6c6c6_8e4da1bc};
    vecs[6] = '{128'h01234567_89abcdef_fedcba98_76543210, 1'b1, 1'b1,
                128'h01234567_89abcdef_fedcba98_76543210};
    vecs[7] = '{128'h0, 1'b0, 1'b0, 128'h0};

    rst = 1'b1; in_valid = 1'b0; inv_en = 1'b0; bypass_en = 1'b0;
    out_ready = 1'b1; mix_in = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset mix_o", k, mix_o_w[k], 128'h0);
      check("reset out_valid", k, 128'(out_valid_w[k]), 128'd0);
      check("reset in_ready", k, 128'(in_ready_w[k]), 128'd1);
      check("reset busy", k, 128'(busy_w[k]), 128'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++)
      run_block($sformatf("vec%0d", v), vecs[v].din, vecs[v].inv, vecs[v].byp, vecs[v].dout);

    // Backpressure: result must hold while inputs churn and out_ready stays low.
    out_ready = 1'b0;
    hold_exp  = vecs[0].dout;
    @(negedge clk);
    mix_in = vecs[0].din; inv_en = 1'b0; bypass_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    all_valid = out_valid_w;
    while (all_valid != 3'b111 && n < 20) begin
      @(posedge clk); #1;
      n++;
      all_valid = out_valid_w;
    end
    check("bp all valid", 0, 128'(all_valid), 128'h7);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      inv_en = ~inv_en; bypass_en = c[0];
      mix_in = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        check("bp mix_o", k, mix_o_w[k], hold_exp);
        check("bp out_valid", k, 128'(out_valid_w[k]), 128'd1);
        check("bp in_ready", k, 128'(in_ready_w[k]), 128'd0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; inv_en = 1'b0; bypass_en = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check("bp release in_ready", k, 128'(in_ready_w[k]), 128'd1);
      check("bp release out_valid", k, 128'(out_valid_w[k]), 128'd0);
      check("bp release busy", k, 128'(busy_w[k]), 128'd0);
    end
    $display("[TB] backpressure hold of 10 cycles done");

    // Reset asserted during the second BUSY cycle.
    out_ready = 1'b0;
    @(negedge clk);
    mix_in = vecs[0].din; inv_en = 1'b0; bypass_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check("midrst mix_o", k, mix_o_w[k], 128'h0);
      check("midrst out_valid", k, 128'(out_valid_w[k]), 128'd0);
      check("midrst in_ready", k, 128'(in_ready_w[k]), 128'd1);
    end
    $display("[TB] reset during BUSY applied");
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    run_block("after_reset", 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5, 1'b0, 1'b0,
              128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_columns_iter.md
Name: mix_columns_iter

Overview:
- Iterative AES MixColumns / InvMixColumns stage. Sits directly downstream of the ShiftRows stage in the round datapath and consumes its 128-bit state output.
- Processes COLS_PER_CYCLE columns per clock under a valid/ready handshake on both sides. A bypass input skips the mix for the final encryption round.
- Inverse mode supports decryption in the same datapath.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per BUSY cycle. Legal values are 1, 2 and 4; any other value is a elaboration error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mix_in  input  128  state from ShiftRows. AES column c (0..3) is at bits [127-32c -: 32]; row 0 is the MSB byte of each word (FIPS-197 order).
- in_valid  input  1  mix_in, inv_en and bypass_en are valid.
- in_ready  output  1  stage can accept a block (high only in IDLE).
- inv_en  input  1  0 selects MixColumns; 1 selects InvMixColumns. Sampled on accept.
- bypass_en  input  1  1 makes the output equal the input unchanged. Sampled on accept.
- mix_o  output  128  result, same byte layout as mix_in.
- out_valid  output  1  mix_o holds a completed result.
- out_ready  input  1  downstream accepts mix_o.
- busy_o  output  1  high in BUSY or DONE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE; column counter = 0; internal state register = 0.
  - mix_o = 0, out_valid = 0, in_ready = 1, busy_o = 0.
  - Reset overrides everything, including a transfer in progress; a partially processed block is discarded.
- IDLE:
  - in_ready = 1.
  - Accept occurs when in_valid=1 at an edge: latch mix_in, inv_en and bypass_en.
  - If bypass_en=1, go to DONE; otherwise go to BUSY with counter = 0.
- BUSY:
  - in_ready = 0.
  - Each cycle, replace columns counter .. counter+COLS_PER_CYCLE-1 of the held state with their transformed value; counter advances by COLS_PER_CYCLE.
  - After the cycle that processes column 3, go to DONE.
  - BUSY lasts 4/COLS_PER_CYCLE cycles; in_valid is ignored.
- DONE:
  - out_valid = 1 and mix_o = held state.
  - Both are stable while out_ready = 0; no timeout.
  - out_ready=1 at an edge completes the transfer: go to IDLE, out_valid drops next cycle.
  - A new accept is not possible in the same cycle.
- Latency, accept edge to first edge with out_valid high:
  - 4/COLS_PER_CYCLE + 1 cycles (5 for the default).
  - 1 cycle in bypass.
- mix_o is registered; it updates only when the final column is written or in bypass.
- Per-column arithmetic (bytes a0..a3, row 0 first), all in GF(2^8) with polynomial x^8+x^4+x^3+x+1 (0x11B):
  - Forward: b_r = 2·a_r ^ 3·a_{r+1} ^ a_{r+2} ^ a_{r+3}, indices mod 4.
  - Inverse: coefficients 0e, 0b, 0d, 09 in the same rotation.
- xtime(x) = (x<<1) ^ (x[7] ? 8'h1B : 0). Multiplication by 3, 9, b, d and e is built only from xtime and XOR.
- inv_en and bypass_en changing while BUSY or DONE have no effect; the values latched at accept are used.

Test Plan:
- Forward, default parameter.
  - mix_in = 128'hdb135345_f20a225c_01010101_c6c6c6c6, inv_en=0, bypass_en=0.
  - Required: mix_o = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6; out_valid high exactly 5 cycles after the accept edge.
- Inverse.
  - mix_in = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, inv_en=1.
  - Required: mix_o = 128'hdb135345_f20a225c_01010101_c6c6c6c6.
- Bypass.
  - mix_in = 128'hd4d4d4d5_2d26314c_00112233_44556677, bypass_en=1.
  - Required: the identical value on mix_o 1 cycle after accept.
- Backpressure.
  - Hold out_ready=0 for 10 cycles in DONE; toggle inv_en and mix_in during that time.
  - Required: mix_o and out_valid stable, in_ready=0 throughout.
  - Then out_ready=1: IDLE and in_ready=1 on the next cycle.
- Reset mid-operation.
  - Assert rst on the 2nd BUSY cycle.
  - Required: the next cycle shows mix_o=0, out_valid=0, in_ready=1.
  - A fresh block (column d4d4d4d5 in all four columns) then gives d5d5d7d6 in each column.
- Parameter sweep, COLS_PER_CYCLE=2 and 4.
  - Repeat scenarios 1 and 2.
  - Required: same results, with latency 3 and 2 cycles respectively.
